// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for one arbiter-PUF instance: drives challenge, arbiter reset and race pulse,
// repeats NUM_EVAL evaluations and returns the majority-voted response bit with its ones-count.
module apuf_eval_ctrl #(
  parameter int unsigned CHAL_W         = 8,
  parameter int unsigned NUM_EVAL       = 7,
  parameter int unsigned ARB_RST_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [CHAL_W-1:0] chal_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [3:0]        resp_ones,
  output logic              resp_error,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_pulse,
  output logic              puf_reset,
  input  logic              puf_result,
  input  logic              puf_done
);

  localparam int unsigned PhMax = (ARB_RST_CYCLES > SETTLE_CYCLES) ? ARB_RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArbRst,
    StSettle,
    StWaitDone,
    StResult
  } state_e;

  state_e            state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [3:0]        eval_q, eval_d;
  logic [3:0]        ones_q, ones_d;
  logic              err_q, err_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [1:0]        done_sync_q, result_sync_q;
  logic              chal_ready_q, resp_valid_q, puf_reset_q, puf_pulse_q;
  logic              done_s, result_s;

  assign done_s   = done_sync_q[1];
  assign result_s = result_sync_q[1];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    eval_d  = eval_q;
    ones_d  = ones_q;
    err_d   = err_q;
    chal_d  = chal_q;
    unique case (state_q)
      StIdle: begin
        if (chal_valid && chal_ready_q) begin
          chal_d  = chal_data;
          ones_d  = '0;
          eval_d  = '0;
          err_d   = 1'b0;
          phase_d = '0;
          state_d = StArbRst;
        end
      end
      StArbRst: begin
        if (phase_q == PhW'(ARB_RST_CYCLES - 1)) begin
          phase_d = '0;
          state_d = StSettle;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StSettle: begin
        if (phase_q == PhW'(SETTLE_CYCLES - 1)) begin
          phase_d = '0;
          tmo_d   = '0;
          state_d = StWaitDone;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StWaitDone: begin
        tmo_d = tmo_q + 1'b1;
        // A done arriving on the timeout cycle still counts as a valid evaluation.
        if (done_s) begin
          ones_d  = ones_q + 4'(result_s);
          eval_d  = eval_q + 4'd1;
          state_d = (eval_d == 4'(NUM_EVAL)) ? StResult : StArbRst;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResult;
        end
      end
      StResult: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and PUF control outputs are registered from the next state so they switch
  // together with the state register and stay glitch-free toward the analog core.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      tmo_q         <= '0;
      eval_q        <= '0;
      ones_q        <= '0;
      err_q         <= 1'b0;
      chal_q        <= '0;
      done_sync_q   <= '0;
      result_sync_q <= '0;
      chal_ready_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      puf_reset_q   <= 1'b1;
      puf_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      tmo_q         <= tmo_d;
      eval_q        <= eval_d;
      ones_q        <= ones_d;
      err_q         <= err_d;
      chal_q        <= chal_d;
      done_sync_q   <= {done_sync_q[0], puf_done};
      result_sync_q <= {result_sync_q[0], puf_result};
      chal_ready_q  <= (state_d == StIdle);
      resp_valid_q  <= (state_d == StResult);
      puf_reset_q   <= (state_d == StIdle) || (state_d == StArbRst) || (state_d == StResult);
      puf_pulse_q   <= (state_d == StWaitDone);
    end
  end

  assign chal_ready    = chal_ready_q;
  assign resp_valid    = resp_valid_q;
  assign puf_challenge = chal_q;
  assign puf_reset     = puf_reset_q;
  assign puf_pulse     = puf_pulse_q;
  assign resp_ones     = resp_valid_q ? ones_q : 4'd0;
  assign resp_error    = resp_valid_q & err_q;
  assign resp_bit      = resp_valid_q && !err_q && (ones_q > 4'(NUM_EVAL / 2));

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl with a behavioural PUF core and a response reference model.
module tb_apuf_eval_ctrl;

  localparam int NEVAL  = 7;
  localparam int ARB    = 2;
  localparam int SETTLE = 4;
  localparam int TMO    = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       chal_valid = 1'b0;
  logic       chal_ready;
  logic [7:0] chal_data = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       resp_bit;
  logic [3:0] resp_ones;
  logic       resp_error;
  logic [7:0] puf_challenge;
  logic       puf_pulse;
  logic       puf_reset;
  logic       puf_result = 1'b0;
  logic       puf_done = 1'b0;

  int checks = 0;
  int errors = 0;

  apuf_eval_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .chal_valid   (chal_valid),
    .chal_ready   (chal_ready),
    .chal_data    (chal_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_bit     (resp_bit),
    .resp_ones    (resp_ones),
    .resp_error   (resp_error),
    .puf_challenge(puf_challenge),
    .puf_pulse    (puf_pulse),
    .puf_reset    (puf_reset),
    .puf_result   (puf_result),
    .puf_done     (puf_done)
  );

  always #5 clock = ~clock;

  // PUF core: result sequence for the current request, indexed by evaluation number.
  logic [6:0] res_seq = 7'h00;
  bit         done_en = 1'b1;
  int         midx = 0;

  always @(negedge clock) begin
    if (!reset_n || puf_reset) begin
      puf_done   = 1'b0;
      puf_result = 1'b0;
      if (!reset_n || chal_ready) midx = 0;
    end else if (puf_pulse && !puf_done && done_en && midx < NEVAL) begin
      puf_done   = 1'b1;
      puf_result = res_seq[midx];
      midx++;
    end
  end

  // Waveform monitor: run lengths of arbiter reset / settle / pulse phases per evaluation.
  logic [7:0] exp_chal = 8'h00;
  int  rst_len[$];
  int  settle_len[$];
  int  pulse_len[$];
  int  rst_run = 0, settle_run = 0, pulse_run = 0, chal_bad = 0;
  bit  prev_pulse = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      rst_run = 0; settle_run = 0; pulse_run = 0; prev_pulse = 1'b0;
    end else begin
      if (puf_pulse) begin
        if (!prev_pulse) begin
          rst_len.push_back(rst_run);
          settle_len.push_back(settle_run);
          rst_run = 0; settle_run = 0; pulse_run = 0;
        end
        pulse_run++;
      end else begin
        if (prev_pulse) pulse_len.push_back(pulse_run);
        if (chal_ready || resp_valid) begin
          rst_run = 0; settle_run = 0;
        end else if (puf_reset) rst_run++;
        else settle_run++;
      end
      if (!puf_reset && puf_challenge !== exp_chal) chal_bad++;
      prev_pulse = puf_pulse;
    end
  end

  task automatic send_chal(input logic [7:0] c, input logic [6:0] s, input bit en, output bit ok);
    exp_chal = c; res_seq = s; done_en = en; ok = 1'b0;
    chal_data = c; chal_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (chal_ready) begin
        @(posedge clock); #1;
        ok = 1'b1;
        break;
      end
    end
    chal_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clock); #1;
  endtask

  task automatic run_req(input logic [7:0] c, input logic [6:0] s, input bit en, output bit got,
                         output int nev, output int bad_tim, output int bad_chal);
    int b0, c0;
    bit ok;
    b0 = rst_len.size(); c0 = chal_bad; got = 1'b0;
    send_chal(c, s, en, ok);
    if (ok) wait_resp(got);
    nev = rst_len.size() - b0;
    bad_tim = 0;
    for (int i = b0; i < rst_len.size(); i++)
      if (rst_len[i] != ARB || settle_len[i] != SETTLE) bad_tim++;
    bad_chal = chal_bad - c0;
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({puf_challenge, puf_pulse, puf_reset, chal_ready, resp_valid, resp_bit, resp_ones, resp_error}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %h %b%b%b%b%b %h %b want 00 01000 0 0", puf_challenge,
               puf_pulse, puf_reset, chal_ready, resp_valid, resp_bit, resp_ones, resp_error);
    end
    @(negedge clock); reset_n = 1'b1; #1;
    checks++;
    if (chal_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b want 0", chal_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({chal_ready, puf_reset} !== 2'b11) begin
      errors++; $display("FAIL ready_after_edge got %b%b want 11", chal_ready, puf_reset);
    end
  endtask

  // Expected response derived from the per-evaluation results: ones-count and strict majority.
  task automatic check_resp(input string name, input logic [6:0] s, input bit got, input int nev,
                            input int bad_tim, input int bad_chal);
    int  eo;
    bit  eb;
    eo = $countones(s);
    eb = (eo > NEVAL / 2);
    checks++;
    if (!got || {resp_bit, resp_ones, resp_error} !== {eb, 4'(eo), 1'b0}) begin
      errors++;
      $display("FAIL %s resp got v%b b%b ones%0d e%b want v1 b%b ones%0d e0", name, got, resp_bit,
               resp_ones, resp_error, eb, eo);
    end
    checks++;
    if (nev != NEVAL || bad_tim != 0 || bad_chal != 0) begin
      errors++;
      $display("FAIL %s_seq got evals %0d bad_phase %0d bad_chal %0d want %0d 0 0", name, nev,
               bad_tim, bad_chal, NEVAL);
    end
  endtask

  task automatic test_nominal();
    bit got; int nev, bt, bc;
    run_req(8'hA5, 7'b1111111, 1'b1, got, nev, bt, bc);
    check_resp("nominal", 7'b1111111, got, nev, bt, bc);
    ack_resp();
  endtask

  task automatic test_majority();
    bit got; int nev, bt, bc;
    run_req(8'h3C, 7'b0010101, 1'b1, got, nev, bt, bc);
    check_resp("maj_three", 7'b0010101, got, nev, bt, bc);
    ack_resp();
    run_req(8'hC3, 7'b0001111, 1'b1, got, nev, bt, bc);
    check_resp("maj_four", 7'b0001111, got, nev, bt, bc);
    ack_resp();
  endtask

  task automatic test_back_to_back();
    bit got; int nev, bt, bc;
    logic [7:0] c;
    logic [6:0] s;
    for (int k = 0; k < 6; k++) begin
      c = 8'($urandom); s = 7'($urandom);
      run_req(c, s, 1'b1, got, nev, bt, bc);
      check_resp("random", s, got, nev, bt, bc);
      ack_resp();
    end
  endtask

  task automatic test_timeout();
    bit got; int nev, bt, bc, pl;
    run_req(8'h5A, 7'b1111111, 1'b0, got, nev, bt, bc);
    checks++;
    if (!got || {resp_bit, resp_ones, resp_error} !== {1'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_resp got v%b b%b ones%0d e%b want v1 b0 ones0 e1", got, resp_bit,
               resp_ones, resp_error);
    end
    pl = (pulse_len.size() > 0) ? pulse_len[pulse_len.size() - 1] : -1;
    checks++;
    if (pl != TMO || nev != 1) begin
      errors++; $display("FAIL timeout_len got %0d evals %0d want %0d 1", pl, nev, TMO);
    end
    ack_resp();
    run_req(8'h96, 7'b1111111, 1'b1, got, nev, bt, bc);
    check_resp("after_timeout", 7'b1111111, got, nev, bt, bc);
    ack_resp();
  endtask

  task automatic test_backpressure();
    bit got; int nev, bt, bc, eo;
    logic [6:0] s;
    s = 7'($urandom);
    eo = $countones(s);
    run_req(8'h71, s, 1'b1, got, nev, bt, bc);
    check_resp("bp_first", s, got, nev, bt, bc);
    for (int k = 0; k < 10; k++) begin
      chal_valid = 1'b1; chal_data = 8'h8E;
      @(posedge clock); #1;
      checks++;
      if ({resp_valid, resp_bit, resp_ones, chal_ready, puf_challenge}
          !== {1'b1, 1'(eo > NEVAL / 2), 4'(eo), 1'b0, 8'h71}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v%b b%b ones%0d rdy%b chal%h want v1 ones%0d rdy0 chal71",
                 k, resp_valid, resp_bit, resp_ones, chal_ready, puf_challenge, eo);
      end
    end
    chal_valid = 1'b0;
    ack_resp();
    checks++;
    if ({chal_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release got rdy%b v%b want rdy1 v0", chal_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got, prev, seen_v; int nev, bt, bc, rises;
    send_chal(8'hE7, 7'b1111111, 1'b1, ok);
    rises = 0; prev = 1'b0; seen_v = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(posedge clock); #1;
      if (puf_pulse && !prev) rises++;
      prev = puf_pulse;
    end
    checks++;
    if (!ok || rises != 3) begin
      errors++; $display("FAIL mid_reach got accepted %b pulses %0d want 1 3", ok, rises);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({puf_pulse, puf_reset, resp_valid, chal_ready} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset got p%b r%b v%b rdy%b want p0 r1 v0 rdy0", puf_pulse, puf_reset,
               resp_valid, chal_ready);
    end
    repeat (3) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen_v = 1'b1;
    end
    checks++;
    if (seen_v) begin
      errors++; $display("FAIL mid_no_resp got resp_valid 1 want 0");
    end
    run_req(8'h18, 7'b1000011, 1'b1, got, nev, bt, bc);
    check_resp("after_mid_reset", 7'b1000011, got, nev, bt, bc);
    ack_resp();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_majority();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Sequencer for one 8-stage arbiter-PUF instance.
- Accepts a challenge over a valid/ready handshake and drives the challenge bits, the arbiter reset and the race pulse.
- Repeats the evaluation NUM_EVAL times, takes a majority vote over the sampled arbiter results, and returns one response bit plus the ones-count over a second valid/ready handshake.
- Sits between the host/test logic and the PUF core. The PUF core's async Result/Done are synchronised here.

Parameters:
- CHAL_W, 8, challenge width; equals the number of PUF stages.
- NUM_EVAL, 7, evaluations per challenge; odd, 1..15.
- ARB_RST_CYCLES, 2, cycles Puf_reset is held high before each evaluation; ≥1.
- SETTLE_CYCLES, 4, cycles with reset low and pulse low before firing; ≥1.
- TIMEOUT, 255, max cycles in WAIT_DONE before aborting; ≥4.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Chal_valid  in  1  challenge request valid.
- Chal_ready  out  1  controller can accept a challenge.
- Chal_data  in  CHAL_W  challenge.
- Resp_valid  out  1  response available.
- Resp_ready  in  1  consumer accepts response.
- Resp_bit  out  1  majority-voted PUF response.
- Resp_ones  out  4  number of evaluations that returned 1.
- Resp_error  out  1  request aborted on timeout.
- Puf_challenge  out  CHAL_W  to PUF Challenge.
- Puf_pulse  out  1  to PUF Pulse.
- Puf_reset  out  1  to PUF arbiter reset; active-high.
- Puf_result  in  1  PUF result; asynchronous.
- Puf_done  in  1  PUF done; asynchronous.

Behaviour:

Reset
- Reset_n low → state IDLE; all counters 0.
- Outputs: Puf_challenge=0, Puf_pulse=0, Puf_reset=1, Chal_ready=0, Resp_valid=0, Resp_bit=0, Resp_ones=0, Resp_error=0.
- Chal_ready rises on the first clock edge after reset release.
- Reset mid-operation: everything returns to reset values immediately; any in-flight request is discarded and no response is produced.

Synchronisers
- Puf_done and Puf_result each pass through a 2-flop synchroniser (reset 0).
- All decisions use the synchronised versions (done_s, result_s).

States
- IDLE
  - Chal_ready=1, Puf_reset=1, Puf_pulse=0.
  - On Chal_valid&&Chal_ready: latch Chal_data into Puf_challenge, clear ones_cnt and eval_cnt, go to ARB_RST.
  - Puf_challenge holds this value until the next accept.
- ARB_RST
  - Puf_reset=1, Puf_pulse=0 for exactly ARB_RST_CYCLES cycles, then go to SETTLE.
- SETTLE
  - Puf_reset=0, Puf_pulse=0 for exactly SETTLE_CYCLES cycles, then go to WAIT_DONE.
- WAIT_DONE
  - Puf_reset=0, Puf_pulse=1; tmo_cnt counts cycles in this state.
  - On done_s=1: ones_cnt += result_s, eval_cnt += 1.
    - If eval_cnt (new value) == NUM_EVAL, go to RESULT.
    - Otherwise go to ARB_RST; Puf_pulse drops in the same transition.
  - If tmo_cnt reaches TIMEOUT with done_s=0: set the error flag and go to RESULT.
  - If done_s=1 and the timeout occur in the same cycle, done wins.
- RESULT
  - Puf_reset=1, Puf_pulse=0, Resp_valid=1.
  - Resp_ones=ones_cnt.
  - Resp_bit = (ones_cnt > NUM_EVAL/2) && !error; on error Resp_bit=0.
  - Resp_error = error flag.
  - All response outputs are stable while Resp_valid=1 && !Resp_ready.
  - On Resp_ready: Resp_valid=0, go to IDLE, clear the error flag.
  - Chal_ready=0 in every state except IDLE; there is no overlap or pipelining of requests.

Arithmetic and timing
- ones_cnt, eval_cnt: 4 bits. tmo_cnt: width clog2(TIMEOUT+1).
- Puf_done is assumed to have dropped after Puf_reset; done_s must be 0 on entry to WAIT_DONE.
- Per-evaluation cycle count = ARB_RST_CYCLES + SETTLE_CYCLES + (cycles in WAIT_DONE until done_s=1).
- Resp_valid rises on the edge that leaves the last WAIT_DONE.

Test Plan:
- Reset and idle: Reset_n low, then high → all outputs at reset values; Chal_ready=1 one cycle after release; Puf_reset=1.
- Nominal, all ones: Chal_data=8'hA5; PUF model raises Done 1 cycle after Pulse with Result=1 →
  - Puf_challenge=8'hA5 throughout.
  - 7 evaluations, each with reset high 2 / settle 4 / pulse high until done_s.
  - Response: Resp_bit=1, Resp_ones=7, Resp_error=0.
- Majority boundary: Result sequence 1,0,1,0,1,0,0 → Resp_ones=3, Resp_bit=0. Sequence 1,1,1,1,0,0,0 → Resp_ones=4, Resp_bit=1.
- Timeout: Done never asserts → after 255 cycles in WAIT_DONE, Resp_valid=1, Resp_error=1, Resp_bit=0.
  - Then the next challenge completes cleanly with Resp_error=0.
- Backpressure: hold Resp_ready=0 for 10 cycles →
  - Resp_valid/Resp_bit/Resp_ones are stable.
  - Chal_ready=0 and Chal_valid is ignored.
  - Resp_ready=1 → IDLE on the next cycle.
- Reset mid-eval: assert Reset_n low during the 3rd WAIT_DONE → Puf_pulse=0 and Puf_reset=1 immediately, no Resp_valid; a new request after release is evaluated from eval 0.
